// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
//   NUM_REQ       - number of requesters sharing the mux
//   SEL_W         - width of the mux select {S1,S0}
//   state_t       - arbiter state (idle / one holder)
//   onehot_to_idx - converts a one-hot grant vector to its index
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } state_t;

  // OR-reduction encoder: exact for one-hot input, 0 for all-zero input.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
//   req   - request vector
//   mask  - eligible requesters (1 = may win)
//   ptr   - highest-priority index; scan proceeds ptr, ptr+1, ... mod 4
//   valid - at least one eligible request
//   idx   - index of the winner (0 when valid=0)
import mux_arb_pkg::*;

module rr_pick4 (
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   ptr,
  output logic               valid,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [SEL_W-1:0]   pos;

  always_comb begin
    cand  = req & mask;
    valid = |cand;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // SEL_W-bit add wraps naturally modulo NUM_REQ
      pos = ptr + SEL_W'(k);
      if (!found && cand[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the S1/S0 selects of a shared 4:1 mux.
// A grant is held until the holder pulses done, drops its request, or
// (with MAX_HOLD != 0) holds for MAX_HOLD cycles while another request waits.
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   req     - per-requester request; req[i] selects mux input Ii
//   done    - release pulse; only honoured from the current holder
//   gnt     - registered one-hot grant, zero when idle
//   sel     - registered mux select {S1,S0}; holds last value when idle
//   busy    - registered, 1 while a grant is active
//   timeout - registered one-cycle pulse on timeout preemption
import mux_arb_pkg::*;

module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [SEL_W-1:0]   sel_d;
  logic               busy_d;
  logic               to_d;

  logic [SEL_W-1:0]   holder;
  logic [SEL_W-1:0]   pick_ptr;
  logic               pick_valid;
  logic [SEL_W-1:0]   pick_idx;
  logic               others;
  logic               rel_done;
  logic               rel_drop;
  logic               to_hit;
  logic               release_now;

  assign holder = onehot_to_idx(gnt);

  // One picker serves both cases: in IDLE gnt is zero so ~gnt masks nothing
  // and ptr_q is used; in GRANT the holder is masked and the scan starts at
  // holder+1, which is exactly the ptr value committed on this release.
  assign pick_ptr = (state_q == ST_GRANT) ? holder + SEL_W'(1) : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .mask  (~gnt),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign others      = |(req & ~gnt);
  assign rel_done    = |(done & gnt);
  assign rel_drop    = ~|(req & gnt);
  assign to_hit      = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST) && others;
  assign release_now = rel_done || rel_drop || to_hit;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    sel_d   = sel;
    busy_d  = busy;
    to_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          ptr_d = holder + SEL_W'(1);
          to_d  = to_hit && !rel_done && !rel_drop;
          cnt_d = '0;
          if (pick_valid) begin
            gnt_d = NUM_REQ'(1) << pick_idx;
            sel_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      sel     <= sel_d;
      busy    <= busy_d;
      timeout <= to_d;
    end
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 mux between four requesters. It generates the registered S1/S0 selects (sel[1]=S1, sel[0]=S0) plus one-hot grants. The grant is held until the holder signals done, drops its request, or exceeds a hold-time limit while others wait. It sits directly in front of mux_4to1 and drives that mux's select lines.

Parameters:
MAX_HOLD, 16, max cycles a holder keeps the grant while another request is pending; 0 disables timeout
CNT_W, 5, hold counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  4  request per requester; req[i] selects mux input Ii
done  input  4  one-cycle release pulse; only done[i] with gnt[i]=1 is honoured
gnt  output  4  registered one-hot grant; all-zero when idle
sel  output  2  registered mux select {S1,S0}; equals index of gnt bit while busy
busy  output  1  registered; 1 while any grant is active
timeout  output  1  registered one-cycle pulse when a holder is preempted by timeout

Behaviour:
- Reset (async, immediate, also mid-grant): gnt=0000, sel=00, busy=0, timeout=0, ptr=0 (req0 has top priority), hold_cnt=0, state=IDLE.
- States: IDLE (no grant), GRANT (one holder).
- Pick rule: the winner is the first asserted req at or after ptr, scanning cyclically upward (ptr, ptr+1, ... mod 4).
- IDLE: if req!=0, the next edge enters GRANT with gnt=onehot(winner), sel=winner, busy=1, and hold_cnt=0. Latency from req to gnt is exactly 1 cycle. If req=0, stay in IDLE.
- GRANT: hold_cnt increments each cycle and saturates at MAX_HOLD.
- Release condition (evaluated on the current cycle's inputs):
  - done[holder]=1, or
  - req[holder]=0, or
  - timeout: MAX_HOLD!=0, hold_cnt==MAX_HOLD-1, and another req is pending.
- On release: ptr <= holder+1 mod 4. If any other req is pending (holder excluded), the new winner (picked with the updated ptr) gets the grant on the same edge with no idle bubble, and hold_cnt=0. Otherwise go to IDLE: gnt=0000, busy=0, and sel holds its last value.
- timeout=1 for one cycle only when the release was caused solely by the timeout condition. If done or a req drop coincides with timeout, timeout stays 0.
- Holder alone with timeout reached: no preemption. The grant is kept and hold_cnt saturates.
- done[j] or req changes from non-holders: ignored during GRANT, except as pending requests.
- Holder re-asserts req on the cycle after release: treated as a normal requester, now at lowest priority.
- gnt and sel change only on clock edges. Glitch-free at the mux select by construction.
- Invariants: gnt is always one-hot or zero; busy == |gnt; when busy, sel == encode(gnt).

Decomposition:
- Package mux_arb_pkg: NUM_REQ=4, SEL_W=2, state enum {ST_IDLE, ST_GRANT}, and an onehot-to-index encode function.
- Sub-module rr_pick4: purely combinational. Inputs are req[3:0], a mask[3:0] excluding the holder, and ptr[1:0]. Outputs are valid and idx[1:0]. It is reused for both the idle pick and the back-to-back pick.
- Top level holds the state register, ptr, hold_cnt and output registers.

Test Plan:
- Reset then req=0101 held, no done, MAX_HOLD=0 -> one cycle after req: gnt=0001, sel=00, busy=1; holds indefinitely; timeout stays 0.
- req=1111, each holder pulses done 2 cycles after its grant -> grant order 0,1,2,3,0 (sel 00,01,10,11,00), no idle cycle between grants.
- MAX_HOLD=4, req=0011, no done -> gnt=0001 for exactly 4 cycles, then gnt=0010 with timeout=1 for one cycle; after 4 more cycles gnt=0001.
- MAX_HOLD=4, req=0001 alone for 10 cycles -> gnt stays 0001, timeout never asserts.
- Holder 2 drops req while req=0100 -> next edge gnt=0000, busy=0, sel stays 10. Then req=0101 -> gnt=1000? No: ptr=3, so gnt=0001 (wrap-around), sel=00.
- Assert rst mid-grant between clock edges -> gnt=0000, busy=0, sel=00 immediately, before the next edge. After release, req=1000 -> gnt=1000 one cycle later.
